popcount_pipe: RTL and testbench

Parametrised, pipelined population-count engine that counts the set bits of a DATA_W-bit word. It is the streaming successor to the single-cycle 32-bit popcount: it adds a valid/ready handshake with backpressure and a fixed two-stage pipeline at one word per cycle. It can also keep an optional running accumulation across multi-beat packets. It sits between a data source and any consumer of bit-density statistics.

---
 rtl/popcount_pkg.sv | 18 +
 rtl/popcount_chunk.sv | 15 +
 rtl/popcount_pipe.sv | 100 ++++++++++
 tb/tb_popcount_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// popcount_pkg: shared defaults and width helpers for popcount_pipe and popcount_chunk
package popcount_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int CHUNK_W_DEF = 8;
  localparam int ACC_W_DEF = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int cnt_width(input int n);
    return clog2(n + 1);
  endfunction
  function automatic int nchunk(input int dw, input int cw);
    return dw / cw;
  endfunction
endpackage

// File: rtl/popcount_chunk.sv
// popcount_chunk: combinational set-bit count of one CHUNK_W-bit slice
module popcount_chunk
  import popcount_pkg::*;
#(
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int PCW = cnt_width(CHUNK_W)
) (
  input  logic [CHUNK_W-1:0] data,
  output logic [PCW-1:0]     cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < CHUNK_W; i++) cnt = cnt + PCW'(data[i]);
  end
endmodule

// File: rtl/popcount_pipe.sv
// popcount_pipe: two-stage valid/ready popcount; defining POPCOUNT_ACCUM_EN adds per-packet saturating accumulation
module popcount_pipe
  import popcount_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  localparam int CNT_W = cnt_width(DATA_W),
  localparam int NCHUNK = nchunk(DATA_W, CHUNK_W),
  localparam int PCW = cnt_width(CHUNK_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef POPCOUNT_ACCUM_EN
  input  logic              in_last,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_last,
  output logic              out_sat,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count
);
  if (ACC_W < CNT_W || DATA_W % CHUNK_W != 0) begin : g_param_err
    $error("popcount_pipe: bad DATA_W/CHUNK_W/ACC_W combination");
  end
  logic adv, take, load;
  logic [NCHUNK-1:0][PCW-1:0] chunk_cnt, part_d, part_q;
  logic s1_valid_d, s1_valid_q, out_valid_d, out_valid_q;
  logic [CNT_W-1:0] sum, out_count_d, out_count_q;
  for (genvar c = 0; c < NCHUNK; c++) begin : g_chunk
    popcount_chunk #(.CHUNK_W(CHUNK_W), .PCW(PCW)) u_chunk (
      .data(in_data[c*CHUNK_W +: CHUNK_W]),
      .cnt (chunk_cnt[c])
    );
  end
  always_comb begin
    adv = !out_valid_q || out_ready;
    in_ready = rst_n && enable && adv;
    take = in_valid && in_ready;
    load = adv && s1_valid_q;
    sum = '0;
    for (int i = 0; i < NCHUNK; i++) sum = sum + CNT_W'(part_q[i]);
    s1_valid_d = adv ? take : s1_valid_q;
    part_d = take ? chunk_cnt : part_q;
    out_valid_d = adv ? s1_valid_q : out_valid_q;
    out_count_d = load ? sum : out_count_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      part_q <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      part_q <= part_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
`ifdef POPCOUNT_ACCUM_EN
  logic s1_last_d, s1_last_q, out_last_d, out_last_q, out_sat_d, out_sat_q, open_d, open_q, ovf;
  logic [ACC_W-1:0] out_acc_d, out_acc_q;
  logic [ACC_W:0] acc_next;
  always_comb begin
    open_d = (out_valid_q && out_ready) ? !out_last_q : open_q;
    acc_next = {1'b0, open_d ? out_acc_q : {ACC_W{1'b0}}} + (ACC_W+1)'(sum);
    ovf = acc_next[ACC_W];
    s1_last_d = take ? in_last : s1_last_q;
    out_last_d = load ? s1_last_q : out_last_q;
    out_acc_d = load ? (ovf ? {ACC_W{1'b1}} : acc_next[ACC_W-1:0]) : out_acc_q;
    out_sat_d = load ? (ovf || (open_d && out_sat_q)) : out_sat_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_last_q <= 1'b0;
      out_last_q <= 1'b0;
      out_sat_q <= 1'b0;
      open_q <= 1'b0;
      out_acc_q <= '0;
    end else begin
      s1_last_q <= s1_last_d;
      out_last_q <= out_last_d;
      out_sat_q <= out_sat_d;
      open_q <= open_d;
      out_acc_q <= out_acc_d;
    end
  end
  assign out_acc = out_acc_q;
  assign out_last = out_last_q;
  assign out_sat = out_sat_q;
`endif
endmodule

// File: tb/tb_popcount_pipe.sv
// tb_popcount_pipe: self-checking bench for popcount_pipe (accumulator scenarios when POPCOUNT_ACCUM_EN is defined)
module tb_popcount_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid;
  logic [5:0] out_count;
  int errs = 0;
  int checks = 0;
  logic [31:0] in_q[$];
  int cnt_q[$];
`ifdef POPCOUNT_ACCUM_EN
  logic in_last = 1'b1;
  logic [15:0] out_acc;
  logic out_last, out_sat;
  logic in_ready6, out_valid6, out_last6, out_sat6;
  logic [5:0] out_count6, out_acc6;
  bit inl_q[$], last_q[$], sat_q[$], sat6_q[$];
  int acc_q[$], acc6_q[$];
`endif

  always #5 clk = ~clk;

  popcount_pipe #(.DATA_W(32), .CHUNK_W(8), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef POPCOUNT_ACCUM_EN
    .in_last(in_last), .out_acc(out_acc), .out_last(out_last), .out_sat(out_sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
  );

`ifdef POPCOUNT_ACCUM_EN
  popcount_pipe #(.DATA_W(32), .CHUNK_W(8), .ACC_W(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready6), .in_data(in_data),
    .in_last(in_last), .out_acc(out_acc6), .out_last(out_last6), .out_sat(out_sat6),
    .out_valid(out_valid6), .out_ready(out_ready), .out_count(out_count6)
  );
`endif

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      in_q.push_back(in_data);
`ifdef POPCOUNT_ACCUM_EN
      inl_q.push_back(in_last);
`endif
    end
    if (rst_n && out_valid && out_ready) begin
      cnt_q.push_back(int'(out_count));
`ifdef POPCOUNT_ACCUM_EN
      acc_q.push_back(int'(out_acc));
      last_q.push_back(out_last);
      sat_q.push_back(out_sat);
      acc6_q.push_back(int'(out_acc6));
      sat6_q.push_back(out_sat6);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic clear_q();
    in_q.delete();
    cnt_q.delete();
`ifdef POPCOUNT_ACCUM_EN
    inl_q.delete(); last_q.delete(); sat_q.delete(); acc_q.delete(); acc6_q.delete(); sat6_q.delete();
`endif
  endtask

  task automatic test_reset();
    enable = 1'b1;
    in_valid = 1'b1;
    in_data = '1;
    out_ready = 1'b0;
    repeat (3) tick();
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_count !== 6'd0) begin errs++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
`ifdef POPCOUNT_ACCUM_EN
    checks++; if (out_acc !== 16'd0 || out_last !== 1'b0 || out_sat !== 1'b0) begin
      errs++; $display("FAIL reset_accum: got acc=%0d last=%b sat=%b expected 0 0 0", out_acc, out_last, out_sat);
    end
`endif
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL ready_enable_hi: got %b expected 1", in_ready); end
    enable = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL ready_enable_lo: got %b expected 0", in_ready); end
    enable = 1'b1;
    tick();
  endtask

  task automatic test_sequence();
    logic [31:0] w [3];
    int ex [3];
    w = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0001};
    ex = '{32, 0, 2};
    clear_q();
    out_ready = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 3);
      if (k < 3) in_data = w[k];
      tick();
      if (k >= 1 && k <= 3) begin
        checks++; if (out_valid !== 1'b1 || int'(out_count) != ex[k-1]) begin
          errs++; $display("FAIL seq_cycle%0d: got valid=%b count=%0d expected valid=1 count=%0d", k + 1, out_valid, out_count, ex[k-1]);
        end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL seq_idle_cycle%0d: got valid=%b expected 0", k + 1, out_valid); end
      end
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    logic [31:0] w [3];
    int n;
    w = '{32'h1, 32'h3, 32'h7};
    clear_q();
    out_ready = 1'b0;
    enable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = (in_q.size() < 3);
      if (in_q.size() < 3) in_data = w[in_q.size()];
      tick();
    end
    checks++; if (in_q.size() != 2) begin errs++; $display("FAIL bp_accepts: got %0d expected 2", in_q.size()); end
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_count !== 6'd1) begin
      errs++; $display("FAIL bp_head_hold: got valid=%b count=%0d expected 1 1", out_valid, out_count);
    end
    out_ready = 1'b1;
    n = 0;
    while (cnt_q.size() < 3 && n < 20) begin
      in_valid = (in_q.size() < 3);
      if (in_q.size() < 3) in_data = w[in_q.size()];
      tick();
      n++;
    end
    in_valid = 1'b0;
    idle(3);
    checks++; if (cnt_q.size() != 3) begin errs++; $display("FAIL bp_out_count_n: got %0d expected 3", cnt_q.size()); end
    for (int i = 0; i < cnt_q.size() && i < 3; i++) begin
      checks++; if (cnt_q[i] != i + 1) begin errs++; $display("FAIL bp_out%0d: got %0d expected %0d", i, cnt_q[i], i + 1); end
    end
  endtask

  task automatic test_enable();
    clear_q();
    out_ready = 1'b1;
    enable = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h0000_00FF;
    tick();
    enable = 1'b0;
    in_data = 32'hF0F0_F0F0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL en_in_ready%0d: got %b expected 0", c, in_ready); end
    end
    checks++; if (in_q.size() != 1) begin errs++; $display("FAIL en_accepts: got %0d expected 1", in_q.size()); end
    checks++; if (cnt_q.size() != 1 || (cnt_q.size() > 0 && cnt_q[0] != 8)) begin
      errs++; $display("FAIL en_drain: got n=%0d first=%0d expected n=1 first=8", cnt_q.size(), cnt_q.size() > 0 ? cnt_q[0] : -1);
    end
    enable = 1'b1;
    tick();
    idle(4);
    checks++; if (cnt_q.size() != 2 || (cnt_q.size() > 1 && cnt_q[1] != 16)) begin
      errs++; $display("FAIL en_resume: got n=%0d second=%0d expected n=2 second=16", cnt_q.size(), cnt_q.size() > 1 ? cnt_q[1] : -1);
    end
  endtask

  task automatic test_random();
    bit stalled;
    int prev_cnt, bad;
`ifdef POPCOUNT_ACCUM_EN
    int prev_acc, tot, tot6, p;
    bit sat, sat6;
`endif
    clear_q();
    stalled = 1'b0;
    prev_cnt = 0;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      if (stalled) begin
        checks++; if (out_valid !== 1'b1 || int'(out_count) != prev_cnt) begin
          errs++; $display("FAIL rnd_stall_hold@%0d: got valid=%b count=%0d expected 1 %0d", c, out_valid, out_count, prev_cnt);
        end
`ifdef POPCOUNT_ACCUM_EN
        checks++; if (int'(out_acc) != prev_acc) begin errs++; $display("FAIL rnd_stall_acc@%0d: got %0d expected %0d", c, out_acc, prev_acc); end
`endif
      end
`ifdef POPCOUNT_ACCUM_EN
      checks++; if (out_valid6 !== out_valid || out_count6 !== out_count || in_ready6 !== in_ready || (out_valid && out_last6 !== out_last)) begin
        errs++; $display("FAIL rnd_dut6_match@%0d: got v=%b c=%0d expected v=%b c=%0d", c, out_valid6, out_count6, out_valid, out_count);
      end
      in_last = ($urandom % 4 == 0);
      prev_acc = int'(out_acc);
`endif
      enable = ($urandom % 8 != 0);
      in_valid = ($urandom % 4 != 0);
      in_data = $urandom;
      out_ready = ($urandom % 3 != 0);
      stalled = out_valid && !out_ready;
      prev_cnt = int'(out_count);
      tick();
    end
    enable = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = $urandom;
`ifdef POPCOUNT_ACCUM_EN
    in_last = 1'b1;
`endif
    tick();
    idle(4);
    checks++; if (cnt_q.size() != in_q.size()) begin errs++; $display("FAIL rnd_beats: got %0d outputs expected %0d", cnt_q.size(), in_q.size()); end
    for (int i = 0; i < cnt_q.size() && i < in_q.size(); i++) begin
      checks++; if (cnt_q[i] != $countones(in_q[i])) begin
        errs++; bad++;
        if (bad < 10) $display("FAIL rnd_count%0d: got %0d expected %0d", i, cnt_q[i], $countones(in_q[i]));
      end
    end
`ifdef POPCOUNT_ACCUM_EN
    tot = 0; tot6 = 0; sat = 1'b0; sat6 = 1'b0;
    for (int i = 0; i < acc_q.size() && i < in_q.size(); i++) begin
      p = $countones(in_q[i]);
      tot += p;
      tot6 += p;
      if (tot > 65535) begin tot = 65535; sat = 1'b1; end
      if (tot6 > 63) begin tot6 = 63; sat6 = 1'b1; end
      checks++; if (acc_q[i] != tot || sat_q[i] != sat || last_q[i] != inl_q[i] || acc6_q[i] != tot6 || sat6_q[i] != sat6) begin
        errs++; bad++;
        if (bad < 10) $display("FAIL rnd_acc%0d: got acc=%0d sat=%b acc6=%0d sat6=%b last=%b expected %0d %b %0d %b %b",
                               i, acc_q[i], sat_q[i], acc6_q[i], sat6_q[i], last_q[i], tot, sat, tot6, sat6, inl_q[i]);
      end
      if (inl_q[i]) begin tot = 0; tot6 = 0; sat = 1'b0; sat6 = 1'b0; end
    end
`endif
  endtask

  task automatic test_reset_midflight();
    clear_q();
    out_ready = 1'b0;
    enable = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h0000_00FF;
`ifdef POPCOUNT_ACCUM_EN
    in_last = 1'b0;
`endif
    repeat (2) tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL mid_rst_ready: got %b expected 0", in_ready); end
    checks++; if (cnt_q.size() != 0) begin errs++; $display("FAIL mid_rst_leak: got %0d outputs expected 0", cnt_q.size()); end
`ifdef POPCOUNT_ACCUM_EN
    checks++; if (out_acc !== 16'd0) begin errs++; $display("FAIL mid_rst_acc: got %0d expected 0", out_acc); end
    in_last = 1'b1;
`endif
    rst_n = 1'b1;
    clear_q();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h0000_0001;
    tick();
    idle(4);
    checks++; if (cnt_q.size() != 1 || (cnt_q.size() > 0 && cnt_q[0] != 1)) begin
      errs++; $display("FAIL mid_post_beat: got n=%0d first=%0d expected n=1 first=1", cnt_q.size(), cnt_q.size() > 0 ? cnt_q[0] : -1);
    end
`ifdef POPCOUNT_ACCUM_EN
    checks++; if (acc_q.size() != 1 || (acc_q.size() > 0 && acc_q[0] != 1)) begin
      errs++; $display("FAIL mid_post_acc: got %0d expected 1", acc_q.size() > 0 ? acc_q[0] : -1);
    end
`endif
  endtask

`ifdef POPCOUNT_ACCUM_EN
  task automatic test_accum();
    logic [31:0] w [7];
    bit l [7];
    int e16 [7], e6 [7];
    bit s6 [7];
    w = '{32'hF, 32'hFF, 32'hFFFF, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    l = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    e16 = '{4, 12, 28, 1, 32, 64, 96};
    e6 = '{4, 12, 28, 1, 32, 63, 63};
    s6 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    clear_q();
    out_ready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data = w[i];
      in_last = l[i];
      tick();
    end
    in_last = 1'b1;
    idle(4);
    checks++; if (acc_q.size() != 7) begin errs++; $display("FAIL acc_beats: got %0d expected 7", acc_q.size()); end
    for (int i = 0; i < acc_q.size() && i < 7; i++) begin
      checks++; if (acc_q[i] != e16[i] || sat_q[i] != 1'b0 || last_q[i] != l[i]) begin
        errs++; $display("FAIL acc16_%0d: got acc=%0d sat=%b last=%b expected %0d 0 %b", i, acc_q[i], sat_q[i], last_q[i], e16[i], l[i]);
      end
      checks++; if (acc6_q[i] != e6[i] || sat6_q[i] != s6[i]) begin
        errs++; $display("FAIL acc6_%0d: got acc=%0d sat=%b expected %0d %b", i, acc6_q[i], sat6_q[i], e6[i], s6[i]);
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequence();
    test_backpressure();
    test_enable();
    test_random();
    test_reset_midflight();
`ifdef POPCOUNT_ACCUM_EN
    test_accum();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
